// File: rtl/ypc_pkg.sv
// Shared definitions for the YPC core front end: fetch FSM states,
// instruction size, reset vector and the canonical NOP encoding.
package ypc_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_OUT  = 3'd3,
    S_HALT = 3'd4
  } fetch_state_e;

  localparam logic [31:0] INST_BYTES       = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] NOP              = 32'h0000_0013;

  // Redirect targets are word aligned; the two low bits are forced to zero.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues one imem read at a time,
// registers the returned word and hands it to the decoder with its PC.
// Redirects from execute take priority; an ebreak handoff parks the unit.
module ifu_fetch
  import ypc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32'd32,
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [31:0]           imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [31:0]           inst_pc,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  input  logic                  halt,
  output logic                  halted
);

  fetch_state_e          state_q, state_d;
  logic [31:0]           pc_q, pc_d;
  logic [DATA_WIDTH-1:0] inst_q, inst_d;
  logic [31:0]           inst_pc_q, inst_pc_d;
  logic                  drop_q, drop_d;
  logic [31:0]           redir_pc_s;
  logic                  unused_redir_lsb_s;

  assign redir_pc_s         = align_pc(redirect_pc);
  assign unused_redir_lsb_s = ^redirect_pc[1:0];

  // Next-state logic: redirect first, then the normal fetch progression.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    drop_d    = drop_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        if (redirect_valid) begin
          pc_d = redir_pc_s;
          if (imem_req_ready) begin
            // The old address was accepted; its data must be thrown away.
            drop_d  = 1'b1;
            state_d = S_WAIT;
          end else begin
            state_d = S_REQ;
          end
        end else if (imem_req_ready) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_d = redir_pc_s;
          if (imem_rsp_valid) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            drop_d  = 1'b1;
            state_d = S_WAIT;
          end
        end else if (imem_rsp_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            inst_d    = imem_rsp_data;
            inst_pc_d = pc_q;
            state_d   = S_OUT;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_OUT: begin
        if (redirect_valid) begin
          // Squash the held instruction; halt is not honoured here.
          pc_d    = redir_pc_s;
          state_d = S_REQ;
        end else if (inst_ready) begin
          if (halt) begin
            state_d = S_HALT;
          end else begin
            pc_d    = pc_q + INST_BYTES;
            state_d = S_REQ;
          end
        end else begin
          state_d = S_OUT;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      inst_pc_q <= 32'h0000_0000;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      drop_q    <= drop_d;
    end
  end

  assign imem_req_valid = (state_q == S_REQ);
  assign imem_req_addr  = pc_q;
  assign inst_valid     = (state_q == S_OUT);
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign halted         = (state_q == S_HALT);

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed scenarios plus a randomized
// run checked against a transaction-level model of the fetch stream.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        halted;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] NOP_W = 32'h0000_0013;

  ifu_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  // Memory contents as a pure function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1234_5678;
  endfunction

  task automatic clear_inputs;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    halt           = 1'b0;
  endtask

  // From S_REQ: one request handshake, one-cycle response, ends in S_OUT.
  task automatic fetch_one(input logic [31:0] data);
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got %b want 0", imem_req_valid); end
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL reset_inst_valid got %b want 0", inst_valid); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got %b want 0", halted); end
    checks++; if (inst !== 32'h0) begin failures++; $display("FAIL reset_inst got %h want 0", inst); end
    checks++; if (inst_pc !== 32'h0) begin failures++; $display("FAIL reset_inst_pc got %h want 0", inst_pc); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000) begin failures++; $display("FAIL first_req got v=%b a=%h want v=1 a=80000000", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_basic;
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL wait_no_req got %b want 0", imem_req_valid); end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0010_0093;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    checks++; if (inst_valid !== 1'b1 || inst !== 32'h0010_0093 || inst_pc !== 32'h8000_0000) begin failures++; $display("FAIL basic_out got v=%b i=%h pc=%h want 1 00100093 80000000", inst_valid, inst, inst_pc); end
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0004 || inst_valid !== 1'b0) begin failures++; $display("FAIL basic_next got v=%b a=%h iv=%b want 1 80000004 0", imem_req_valid, imem_req_addr, inst_valid); end
  endtask

  task automatic test_stall;
    fetch_one(32'h0020_0113);
    for (int i = 0; i < 5; i++) begin
      inst_ready = 1'b0;
      checks++; if (inst_valid !== 1'b1 || inst !== 32'h0020_0113 || inst_pc !== 32'h8000_0004 || imem_req_valid !== 1'b0) begin failures++; $display("FAIL stall_hold cyc=%0d got v=%b i=%h pc=%h rq=%b want 1 00200113 80000004 0", i, inst_valid, inst, inst_pc, imem_req_valid); end
      @(negedge clk);
    end
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0008) begin failures++; $display("FAIL stall_next got v=%b a=%h want 1 80000008", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_redirect_wait;
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0103;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin failures++; $display("FAIL redir_wait_hold got rq=%b iv=%b want 0 0", imem_req_valid, inst_valid); end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    checks++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0100) begin failures++; $display("FAIL redir_wait_drop got iv=%b rq=%b a=%h want 0 1 80000100", inst_valid, imem_req_valid, imem_req_addr); end
    fetch_one(NOP_W);
    checks++; if (inst_valid !== 1'b1 || inst !== NOP_W || inst_pc !== 32'h8000_0100) begin failures++; $display("FAIL redir_wait_fetch got v=%b i=%h pc=%h want 1 00000013 80000100", inst_valid, inst, inst_pc); end
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
  endtask

  task automatic test_redirect_out;
    fetch_one(32'h0010_0073);
    inst_ready     = 1'b1;
    halt           = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    @(negedge clk);
    clear_inputs();
    checks++; if (halted !== 1'b0 || inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0200) begin failures++; $display("FAIL redir_out got h=%b iv=%b rq=%b a=%h want 0 0 1 80000200", halted, inst_valid, imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_wrap;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL redir_req got v=%b a=%h want 1 fffffffc", imem_req_valid, imem_req_addr); end
    fetch_one(NOP_W);
    checks++; if (inst_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_inst_pc got %h want fffffffc", inst_pc); end
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_0000) begin failures++; $display("FAIL wrap_next got v=%b a=%h want 1 00000000", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_halt;
    fetch_one(32'h0010_0073);
    inst_ready = 1'b1;
    halt       = 1'b1;
    @(negedge clk);
    clear_inputs();
    checks++; if (halted !== 1'b1 || inst_valid !== 1'b0 || imem_req_valid !== 1'b0) begin failures++; $display("FAIL halt_enter got h=%b iv=%b rq=%b want 1 0 0", halted, inst_valid, imem_req_valid); end
    for (int i = 0; i < 4; i++) begin
      imem_req_ready = 1'b1;
      inst_ready     = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = $urandom;
      @(negedge clk);
      checks++; if (halted !== 1'b1 || imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || imem_req_addr !== 32'h0) begin failures++; $display("FAIL halt_hold cyc=%0d got h=%b rq=%b iv=%b pc=%h want 1 0 0 00000000", i, halted, imem_req_valid, inst_valid, imem_req_addr); end
    end
    clear_inputs();
    rst_n = 1'b0;
    #1;
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL halt_reset got %b want 0", halted); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000) begin failures++; $display("FAIL halt_restart got v=%b a=%h want 1 80000000", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_async_reset;
    fetch_one(32'h1234_5678);
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready     = 1'b0;
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || halted !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0) begin failures++; $display("FAIL async_reset got rq=%b iv=%b h=%b i=%h pc=%h want all 0", imem_req_valid, inst_valid, halted, inst, inst_pc); end
    @(negedge clk);
    rst_n          = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBAD0_BAD0;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000 || inst_valid !== 1'b0) begin failures++; $display("FAIL late_rsp got rq=%b a=%h iv=%b want 1 80000000 0", imem_req_valid, imem_req_addr, inst_valid); end
    fetch_one(NOP_W);
    checks++; if (inst !== NOP_W || inst_pc !== 32'h8000_0000) begin failures++; $display("FAIL late_rsp_fetch got i=%h pc=%h want 00000013 80000000", inst, inst_pc); end
  endtask

  // Randomized run: the model tracks only the architectural fetch PC and
  // the one outstanding memory access; every delivered word must be the
  // memory contents at its own PC, in program order.
  task automatic test_random;
    logic [31:0] exp_pc;
    logic        mem_busy;
    logic [31:0] mem_addr;
    int          mem_cnt;
    int          delivered;
    logic        redir;
    logic [31:0] tgt;
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_pc    = 32'h8000_0000;
    mem_busy  = 1'b0;
    mem_addr  = 32'h0;
    mem_cnt   = 0;
    delivered = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      clear_inputs();
      if (imem_req_valid) begin
        checks++; if (imem_req_addr !== exp_pc || mem_busy) begin failures++; $display("FAIL rand_req cyc=%0d got a=%h busy=%b want a=%h busy=0", cyc, imem_req_addr, mem_busy, exp_pc); end
      end
      if (mem_busy) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(mem_addr);
          mem_busy       = 1'b0;
        end
      end else if ($urandom_range(0, 15) == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = $urandom;
      end
      imem_req_ready = ($urandom_range(0, 2) != 0);
      if (imem_req_valid && imem_req_ready) begin
        mem_busy = 1'b1;
        mem_addr = imem_req_addr;
        mem_cnt  = $urandom_range(1, 3);
      end
      inst_ready = ($urandom_range(0, 1) == 1);
      redir      = ($urandom_range(0, 11) == 0);
      tgt        = $urandom;
      redirect_valid = redir;
      redirect_pc    = tgt;
      if (inst_valid && inst_ready && !redir) begin
        checks++; if (inst_pc !== exp_pc || inst !== mem_word(exp_pc)) begin failures++; $display("FAIL rand_inst cyc=%0d got pc=%h i=%h want pc=%h i=%h", cyc, inst_pc, inst, exp_pc, mem_word(exp_pc)); end
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      if (redir) begin
        exp_pc = {tgt[31:2], 2'b00};
      end
      @(negedge clk);
    end
    clear_inputs();
    checks++; if (delivered < 100) begin failures++; $display("FAIL rand_progress got %0d want >=100", delivered); end
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_basic();
    test_stall();
    test_redirect_wait();
    test_redirect_out();
    test_wrap();
    test_halt();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
